// File: rtl/cmp_unit_arbiter_if.sv
// Signal bundle between the issue side, the shared subtractor and the arbiter:
// two request channels, the subtractor operand/result port and the response channel.
interface cmp_unit_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic             req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic             req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [WIDTH-1:0] sub_a;
   logic [WIDTH-1:0] sub_b;
   logic [WIDTH-1:0] sub_res;
   logic             sub_ovf;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;

   // Master is the surrounding system: requesters, subtract datapath and response consumer.
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output sub_res, sub_ovf, rsp_ready,
      input  req0_ready, req1_ready, sub_a, sub_b,
      input  rsp_valid, rsp_id, rsp_data, rsp_zero
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  sub_res, sub_ovf, rsp_ready,
      output req0_ready, req1_ready, sub_a, sub_b,
      output rsp_valid, rsp_id, rsp_data, rsp_zero
   );
endinterface

// File: rtl/cmp_unit_arbiter.sv
// Round-robin sequencer sharing one subtractor between two requesters; it issues
// SUB/SLT ops, waits SUB_LAT cycles for the difference and returns a tagged response.
module cmp_unit_arbiter #(
   parameter int WIDTH       = 32,
   parameter int SUB_LAT     = 1,
   parameter int SLT_OVF_FIX = 0
) (
   input logic              clk,
   input logic              rst_n,
   cmp_unit_arbiter_if.slave bus
);
   localparam int               CNT_W    = (SUB_LAT > 1) ? $clog2(SUB_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SUB_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } stateT;

   stateT            state;
   stateT            stateNext;
   logic             preferOne;
   logic             opReg;
   logic             idReg;
   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic [CNT_W-1:0] latCnt;
   logic [WIDTH-1:0] rspDataReg;
   logic             rspZeroReg;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             sltBit;

   // Grant only in IDLE: a lone requester wins, a tie goes to the preferred one.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (bus.req0_valid && (!bus.req1_valid || !preferOne)) begin
            grant0 = 1'b1;
         end else if (bus.req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign accept = grant0 | grant1;

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = EXEC;
         EXEC:    if (latCnt == '0) stateNext = RESP;
         RESP:    if (bus.rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // The overflow-corrected rule gives the true signed a<b even when a-b wraps.
   assign sltBit = (SLT_OVF_FIX != 0) ? (bus.sub_res[WIDTH-1] ^ bus.sub_ovf)
                                      : bus.sub_res[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preferOne  <= 1'b0;
         opReg      <= 1'b0;
         idReg      <= 1'b0;
         aReg       <= '0;
         bReg       <= '0;
         latCnt     <= '0;
         rspDataReg <= '0;
         rspZeroReg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  opReg  <= grant0 ? bus.req0_op : bus.req1_op;
                  aReg   <= grant0 ? bus.req0_a  : bus.req1_a;
                  bReg   <= grant0 ? bus.req0_b  : bus.req1_b;
                  idReg  <= grant1;
                  latCnt <= CNT_INIT;
               end
            end
            EXEC: begin
               if (latCnt != '0) begin
                  latCnt <= latCnt - CNT_W'(1);
               end else begin
                  rspDataReg <= opReg ? {{(WIDTH-1){1'b0}}, sltBit} : bus.sub_res;
                  rspZeroReg <= (bus.sub_res == '0);
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  preferOne <= ~idReg;
               end
            end
            default: ;
         endcase
      end
   end

   // Ready is masked by reset so every output reads 0 while rst_n is low.
   assign bus.req0_ready = grant0 & rst_n;
   assign bus.req1_ready = grant1 & rst_n;
   assign bus.sub_a      = aReg;
   assign bus.sub_b      = bReg;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_id     = idReg;
   assign bus.rsp_data   = rspDataReg;
   assign bus.rsp_zero   = rspZeroReg;
endmodule
